// File: rtl/serial_parity_chk.sv
// Serial parity checker: folds framed data bits into a registered XOR
// and compares the trailing parity bit, pulsing done with the verdict.
module serial_parity_chk #(
  parameter int FRAME_LEN = 8,
  parameter bit ODD       = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       busy,
  output logic [7:0] bit_cnt,
  output logic       parity_out,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);

  state_t state;
  logic   acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      acc     <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      // start wins over any bit arriving in the same cycle
      if (start) begin
        state   <= DATA;
        bit_cnt <= '0;
        acc     <= 1'b0;
        err     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
          end
          DATA: begin
            if (bit_valid) begin
              acc     <= acc ^ bit_in;
              bit_cnt <= bit_cnt + 8'd1;
              if (bit_cnt == LAST) begin
                state <= PAR;
              end
            end
          end
          PAR: begin
            if (bit_valid) begin
              err   <= bit_in ^ acc ^ ODD;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign parity_out = acc ^ ODD;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_serial_parity_chk.sv
// Bench for serial_parity_chk: even and odd instances share stimulus and
// are checked every cycle against a queue-based frame model.
module tb_serial_parity_chk;

  localparam int FL = 8;

  logic clk = 1'b0;
  logic rst, start, bit_in, bit_valid;

  logic       busy0, par0, done0, err0;
  logic       busy1, par1, done1, err1;
  logic [7:0] cnt0, cnt1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_parity_chk #(.FRAME_LEN(FL), .ODD(1'b0)) u_even (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .busy(busy0), .bit_cnt(cnt0),
    .parity_out(par0), .done(done0), .err(err0)
  );

  serial_parity_chk #(.FRAME_LEN(FL), .ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .busy(busy1), .bit_cnt(cnt1),
    .parity_out(par1), .done(done1), .err(err1)
  );

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
               $time);
    end
  endtask

  // frame model: the data bits of the current frame in a queue
  bit m_active = 1'b0;
  bit m_bits[$];
  bit m_done = 1'b0;
  bit m_err[2] = '{1'b0, 1'b0};

  function automatic bit ones_par();
    bit x = 1'b0;
    foreach (m_bits[i]) x ^= m_bits[i];
    return x;
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_bits.delete();
      m_err = '{1'b0, 1'b0};
    end else if (start) begin
      m_active = 1'b1;
      m_bits.delete();
      m_err = '{1'b0, 1'b0};
    end else if (m_active && bit_valid) begin
      if (m_bits.size() < FL) begin
        m_bits.push_back(bit_in);
      end else begin
        for (int k = 0; k < 2; k++)
          m_err[k] = (bit_in != (ones_par() ^ k[0]));
        m_done = 1'b1;
        m_active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy0", {7'd0, busy0}, {7'd0, m_active});
      chk("m_busy1", {7'd0, busy1}, {7'd0, m_active});
      chk("m_cnt0", cnt0, 8'(m_bits.size()));
      chk("m_cnt1", cnt1, 8'(m_bits.size()));
      chk("m_par0", {7'd0, par0}, {7'd0, ones_par()});
      chk("m_par1", {7'd0, par1}, {7'd0, ~ones_par()});
      chk("m_done0", {7'd0, done0}, {7'd0, m_done});
      chk("m_done1", {7'd0, done1}, {7'd0, m_done});
      chk("m_err0", {7'd0, err0}, {7'd0, m_err[0]});
      chk("m_err1", {7'd0, err1}, {7'd0, m_err[1]});
    end
  end

  task automatic cyc(input logic s, input logic v, input logic b);
    start = s;
    bit_valid = v;
    bit_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_data(input logic [7:0] d, input int gap);
    for (int i = 0; i < FL; i++) begin
      cyc(1'b0, 1'b1, d[FL-1-i]);
      if (i == 1) begin
        for (int g = 0; g < gap; g++) begin
          cyc(1'b0, 1'b0, 1'b1);
          chk("gap_cnt", cnt0, 8'd2);
        end
      end
    end
  endtask

  task automatic send_par(input logic p, input int gap,
                          input logic e0, input logic e1);
    for (int g = 0; g < gap; g++) begin
      cyc(1'b0, 1'b0, ~p);
      chk("gap_cnt8", cnt0, 8'd8);
    end
    cyc(1'b0, 1'b1, p);
    chk("done_hi", {7'd0, done0}, 8'd1);
    chk("err_even", {7'd0, err0}, {7'd0, e0});
    chk("err_odd", {7'd0, err1}, {7'd0, e1});
    chk("busy_lo", {7'd0, busy0}, 8'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("done_lo", {7'd0, done0}, 8'd0);
    chk("err_held", {7'd0, err0}, {7'd0, e0});
  endtask

  initial begin
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    rst = 1'b0;
    chk("rst_busy", {7'd0, busy0}, 8'd0);
    chk("rst_cnt", cnt0, 8'd0);
    chk("rst_par_even", {7'd0, par0}, 8'd0);
    chk("rst_par_odd", {7'd0, par1}, 8'd1);
    chk("rst_err", {7'd0, err1}, 8'd0);

    // four ones: even parity 0, odd parity 1
    cyc(1'b1, 1'b0, 1'b0);
    send_data(8'b1011_0010, 0);
    chk("a_par_even", {7'd0, par0}, 8'd0);
    chk("a_par_odd", {7'd0, par1}, 8'd1);
    chk("a_cnt", cnt0, 8'd8);
    send_par(1'b0, 0, 1'b0, 1'b1);

    cyc(1'b1, 1'b0, 1'b0);
    send_data(8'b1011_0010, 0);
    send_par(1'b1, 0, 1'b1, 1'b0);

    cyc(1'b1, 1'b0, 1'b0);
    send_data(8'b1011_0010, 3);
    chk("s_par_even", {7'd0, par0}, 8'd0);
    send_par(1'b0, 3, 1'b0, 1'b1);

    // three ones: odd parity 0
    cyc(1'b1, 1'b0, 1'b0);
    send_data(8'b1110_0000, 0);
    chk("o_par_odd", {7'd0, par1}, 8'd0);
    chk("o_par_even", {7'd0, par0}, 8'd1);
    send_par(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    send_data(8'b1110_0000, 0);
    send_par(1'b1, 0, 1'b0, 1'b1);

    // abort mid-frame with a simultaneous bit
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("ab_cnt5", cnt0, 8'd5);
    cyc(1'b1, 1'b1, 1'b1);
    chk("ab_cnt0", cnt0, 8'd0);
    chk("ab_busy", {7'd0, busy0}, 8'd1);
    chk("ab_done", {7'd0, done0}, 8'd0);
    chk("ab_par", {7'd0, par0}, 8'd0);
    send_data(8'b0000_0001, 0);
    send_par(1'b1, 0, 1'b0, 1'b1);

    // reset mid-frame
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    chk("r_busy", {7'd0, busy0}, 8'd0);
    chk("r_cnt", cnt0, 8'd0);
    chk("r_par_odd", {7'd0, par1}, 8'd1);
    chk("r_done", {7'd0, done0}, 8'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("idle_cnt", cnt0, 8'd0);

    // start in the done cycle
    cyc(1'b1, 1'b0, 1'b0);
    send_data(8'b1000_0000, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("sd_done", {7'd0, done0}, 8'd1);
    chk("sd_err", {7'd0, err0}, 8'd1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("sd_done_lo", {7'd0, done0}, 8'd0);
    chk("sd_busy", {7'd0, busy0}, 8'd1);
    chk("sd_err_clr", {7'd0, err0}, 8'd0);

    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_bad);
    $finish;
  end

endmodule
